// File: rtl/ped_signal_ctrl.sv
// ----------------------------------------------------------------------------
// ped_signal_ctrl
//   Pedestrian crossing signal controller slaved to a vehicle lamp.
//   A pedestrian request (live or latched) is served on the rising edge of the
//   vehicle RED lamp: steady WALK, then a flashing DONT_WALK clearance with a
//   countdown, then steady DONT_WALK. Illegal lamp states or a GREEN-to-RED
//   jump without YELLOW lock the controller into FAULT until reset.
//
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   light[2:0]  : vehicle lamp, one-hot {RED,YELLOW,GREEN}
//   ped_btn     : pedestrian request, sampled every cycle
//   walk        : steady WALK lamp
//   dont_walk   : DONT_WALK lamp (steady or flashing)
//   countdown   : clearance cycles remaining during flash, else 0
//   req_pending : latched request not yet served
//   fault       : sticky illegal-lamp flag
// ----------------------------------------------------------------------------
module ped_signal_ctrl #(
   parameter int WALK_TIME  = 8,
   parameter int FLASH_TIME = 12,
   parameter int FLASH_HALF = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] light,
   input  logic       ped_btn,
   output logic       walk,
   output logic       dont_walk,
   output logic [5:0] countdown,
   output logic       req_pending,
   output logic       fault
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WALK  = 2'd1;
   localparam logic [1:0] S_FLASH = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_RED = 3'b100;

   localparam int WT_W = (WALK_TIME  > 1) ? $clog2(WALK_TIME)  : 1;
   localparam int HF_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

   logic [1:0]      r_state;
   logic [2:0]      r_light_d;
   logic [WT_W-1:0] r_walk_tmr;
   logic [HF_W-1:0] r_half;
   logic            r_walk;
   logic            r_dont_walk;
   logic [5:0]      r_countdown;
   logic            r_req;
   logic            r_fault;

   logic w_red_rise;
   logic w_not_red;
   logic w_light_bad;
   logic w_skip_yellow;
   logic w_fault_cond;

   assign w_red_rise    = (light == L_RED) && (r_light_d != L_RED);
   assign w_not_red     = (light != L_RED);
   assign w_light_bad   = (light != L_GRN) && (light != L_YEL) && (light != L_RED);
   // light_d is 000 straight after reset, so this cannot fire on that edge
   assign w_skip_yellow = (r_light_d == L_GRN) && (light == L_RED);
   assign w_fault_cond  = w_light_bad || w_skip_yellow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_light_d   <= '0;
         r_walk_tmr  <= '0;
         r_half      <= '0;
         r_walk      <= 1'b0;
         r_dont_walk <= 1'b1;
         r_countdown <= '0;
         r_req       <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_light_d <= light;
         if (r_state == S_FAULT) begin
            // locked until reset; outputs were set on entry
            r_state <= S_FAULT;
         end else if (w_fault_cond) begin
            r_state     <= S_FAULT;
            r_fault     <= 1'b1;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_countdown <= '0;
            r_req       <= 1'b0;
            r_walk_tmr  <= '0;
            r_half      <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_red_rise && (r_req || ped_btn)) begin
                     // entry consumes any coincident button press
                     r_state     <= S_WALK;
                     r_walk      <= 1'b1;
                     r_dont_walk <= 1'b0;
                     r_req       <= 1'b0;
                     r_walk_tmr  <= WT_W'(WALK_TIME - 1);
                  end else if (ped_btn) begin
                     r_req <= 1'b1;
                  end
               end

               S_WALK: begin
                  if (w_not_red) begin
                     r_state     <= S_IDLE;
                     r_walk      <= 1'b0;
                     r_dont_walk <= 1'b1;
                     r_countdown <= '0;
                  end else if (r_walk_tmr == '0) begin
                     r_state     <= S_FLASH;
                     r_walk      <= 1'b0;
                     r_dont_walk <= 1'b1;
                     r_countdown <= 6'(FLASH_TIME - 1);
                     r_half      <= '0;
                  end else begin
                     r_walk_tmr <= r_walk_tmr - 1'b1;
                  end
               end

               S_FLASH: begin
                  if (ped_btn) begin
                     r_req <= 1'b1;
                  end
                  if (w_not_red) begin
                     r_state     <= S_IDLE;
                     r_dont_walk <= 1'b1;
                     r_countdown <= '0;
                  end else if (r_countdown == '0) begin
                     r_state     <= S_IDLE;
                     r_dont_walk <= 1'b1;
                  end else begin
                     r_countdown <= r_countdown - 1'b1;
                     // half-period counter toggles the lamp on wrap
                     if (r_half == HF_W'(FLASH_HALF - 1)) begin
                        r_half      <= '0;
                        r_dont_walk <= ~r_dont_walk;
                     end else begin
                        r_half <= r_half + 1'b1;
                     end
                  end
               end

               default: begin
                  r_state <= S_FAULT;
               end
            endcase
         end
      end
   end

   assign walk        = r_walk;
   assign dont_walk   = r_dont_walk;
   assign countdown   = r_countdown;
   assign req_pending = r_req;
   assign fault       = r_fault;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ped_signal_ctrl
//   Directed scenarios with literal expectations, followed by a long random
//   run, all compared each cycle against a timeline model of the crossing.
// ----------------------------------------------------------------------------
module tb_ped_signal_ctrl;

   localparam int WT = 8;
   localparam int FT = 12;
   localparam int FH = 2;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] light;
   logic       ped_btn;
   logic       walk;
   logic       dont_walk;
   logic [5:0] countdown;
   logic       req_pending;
   logic       fault;

   int n_pass  = 0;
   int n_total = 0;

   // model: elapsed cycles since WALK entry while a crossing is active
   bit       m_active;
   int       m_t;
   bit       m_req;
   bit       m_fault;
   logic [2:0] m_ld;

   ped_signal_ctrl #(
      .WALK_TIME (WT),
      .FLASH_TIME(FT),
      .FLASH_HALF(FH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .light      (light),
      .ped_btn    (ped_btn),
      .walk       (walk),
      .dont_walk  (dont_walk),
      .countdown  (countdown),
      .req_pending(req_pending),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   function automatic int e_walk();
      return (m_active && m_t < WT) ? 1 : 0;
   endfunction

   function automatic int e_cd();
      return (m_active && m_t >= WT) ? (FT - 1 - (m_t - WT)) : 0;
   endfunction

   function automatic int e_dw();
      if (e_walk() == 1) return 0;
      if (m_active && m_t >= WT) return ((((m_t - WT) / FH) % 2) == 0) ? 1 : 0;
      return 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic pin(input string name, input int dut_v, input int mdl_v, input int lit);
      chk({name, "_dut"}, dut_v, lit);
      chk({name, "_mdl"}, mdl_v, lit);
   endtask

   task automatic model_reset();
      m_active = 0;
      m_t      = 0;
      m_req    = 0;
      m_fault  = 0;
      m_ld     = 3'b000;
   endtask

   task automatic model_step();
      logic [2:0] l;
      bit b;
      bit bad;
      l   = light;
      b   = ped_btn;
      bad = !(l == G || l == Y || l == R) || (m_ld == G && l == R);
      if (m_fault) begin
      end else if (bad) begin
         m_fault  = 1;
         m_active = 0;
         m_req    = 0;
      end else if (m_active) begin
         if (m_t >= WT && b) m_req = 1;
         if (l != R) m_active = 0;
         else begin
            m_t++;
            if (m_t == WT + FT) m_active = 0;
         end
      end else begin
         if (l == R && m_ld != R && (m_req || b)) begin
            m_active = 1;
            m_t      = 0;
            m_req    = 0;
         end else if (b) m_req = 1;
      end
      m_ld = l;
   endtask

   task automatic compare_all();
      chk("walk",        int'(walk),        e_walk());
      chk("dont_walk",   int'(dont_walk),   e_dw());
      chk("countdown",   int'(countdown),   e_cd());
      chk("req_pending", int'(req_pending), int'(m_req));
      chk("fault",       int'(fault),       int'(m_fault));
      chk("mutex",       int'(walk && dont_walk), 0);
   endtask

   // inputs are changed only at the falling edge, then one full cycle runs
   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      else model_reset();
      @(negedge clk);
      compare_all();
   endtask

   task automatic setin(input logic [2:0] l, input logic b);
      light   = l;
      ped_btn = b;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      pin("rst_walk",  int'(walk),        e_walk(),   0);
      pin("rst_dw",    int'(dont_walk),   e_dw(),     1);
      pin("rst_cd",    int'(countdown),   e_cd(),     0);
      pin("rst_req",   int'(req_pending), int'(m_req), 0);
      pin("rst_fault", int'(fault),       int'(m_fault), 0);
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int pat [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
      logic [2:0] colors [3] = '{G, Y, R};
      int ci;
      int dur;
      int stuck;
      int r;
      logic [2:0] lt;

      reset = 1'b0;
      setin(G, 1'b0);
      model_reset();
      @(negedge clk);
      do_reset();

      // normal crossing
      setin(G, 1'b0); tick();
      setin(G, 1'b1); tick();
      pin("n_req_latch", int'(req_pending), int'(m_req), 1);
      setin(G, 1'b0); tick();
      setin(Y, 1'b0); tick(); tick();
      setin(R, 1'b0); tick();
      pin("n_entry_walk", int'(walk), e_walk(), 1);
      pin("n_entry_req",  int'(req_pending), int'(m_req), 0);
      pin("n_entry_dw",   int'(dont_walk), e_dw(), 0);
      for (int i = 1; i < 8; i++) begin
         tick();
         pin("n_walk", int'(walk), e_walk(), 1);
      end
      for (int j = 0; j < 12; j++) begin
         tick();
         pin("n_cd",     int'(countdown), e_cd(), 11 - j);
         pin("n_flash",  int'(dont_walk), e_dw(), pat[j]);
         pin("n_fwalk",  int'(walk), e_walk(), 0);
      end
      for (int i = 0; i < 11; i++) begin
         tick();
         pin("n_idle_dw",  int'(dont_walk), e_dw(), 1);
         pin("n_idle_req", int'(req_pending), int'(m_req), 0);
      end

      // red phase with no request
      setin(G, 1'b0); tick(); tick(); tick();
      setin(Y, 1'b0); tick(); tick();
      setin(R, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick();
         pin("nr_walk", int'(walk), e_walk(), 0);
         pin("nr_dw",   int'(dont_walk), e_dw(), 1);
      end

      // abort at walk cycle 3
      setin(G, 1'b1); tick();
      setin(G, 1'b0); tick();
      setin(Y, 1'b0); tick(); tick();
      setin(R, 1'b0); tick(); tick(); tick();
      setin(G, 1'b0); tick();
      pin("ab_walk",  int'(walk), e_walk(), 0);
      pin("ab_dw",    int'(dont_walk), e_dw(), 1);
      pin("ab_cd",    int'(countdown), e_cd(), 0);
      pin("ab_fault", int'(fault), int'(m_fault), 0);

      // requests during walk and flash
      setin(Y, 1'b1); tick();
      setin(Y, 1'b0); tick();
      setin(R, 1'b0); tick(); tick();
      setin(R, 1'b1); tick();
      pin("rq_walk_ign", int'(req_pending), int'(m_req), 0);
      setin(R, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      pin("rq_flash_cd", int'(countdown), e_cd(), 11);
      setin(R, 1'b1); tick();
      pin("rq_flash_req", int'(req_pending), int'(m_req), 1);
      setin(R, 1'b0);
      for (int i = 0; i < 11; i++) tick();
      pin("rq_end_dw",  int'(dont_walk), e_dw(), 1);
      pin("rq_end_req", int'(req_pending), int'(m_req), 1);
      setin(G, 1'b0); tick(); tick();
      setin(Y, 1'b0); tick(); tick();
      setin(R, 1'b0); tick();
      pin("rq_serve_walk", int'(walk), e_walk(), 1);
      pin("rq_serve_req",  int'(req_pending), int'(m_req), 0);
      for (int i = 0; i < 20; i++) tick();
      setin(G, 1'b0); tick();

      // illegal lamp code, sticky
      setin(3'b011, 1'b0); tick();
      pin("f_bad", int'(fault), int'(m_fault), 1);
      setin(G, 1'b1); tick();
      setin(Y, 1'b0); tick();
      setin(R, 1'b1); tick();
      pin("f_sticky", int'(fault), int'(m_fault), 1);
      pin("f_walk",   int'(walk), e_walk(), 0);
      pin("f_req",    int'(req_pending), int'(m_req), 0);
      setin(R, 1'b0);
      do_reset();
      // first edge after release sees light_d=000 with RED: no fault
      tick();
      pin("f_post_rst", int'(fault), int'(m_fault), 0);
      setin(G, 1'b0); tick(); tick();
      setin(R, 1'b0); tick();
      pin("f_skip_y", int'(fault), int'(m_fault), 1);
      setin(G, 1'b0);
      do_reset();

      // reset mid-flash at countdown 5
      setin(G, 1'b1); tick();
      setin(Y, 1'b0); tick();
      setin(R, 1'b0); tick();
      for (int i = 0; i < 7; i++) tick();
      tick();
      setin(R, 1'b1); tick();
      setin(R, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      pin("mf_cd",  int'(countdown), e_cd(), 5);
      pin("mf_req", int'(req_pending), int'(m_req), 1);
      setin(G, 1'b0);
      do_reset();

      // random traffic
      ci    = 0;
      dur   = 3;
      stuck = 0;
      for (int n = 0; n < 4000; n++) begin
         if (dur == 0) begin
            ci  = (ci + 1) % 3;
            dur = (ci == 2) ? int'($urandom_range(3, 30)) : int'($urandom_range(1, 5));
         end
         dur--;
         lt = colors[ci];
         r  = int'($urandom_range(0, 199));
         if (r == 0) lt = 3'($urandom_range(0, 7));
         else if (r == 1 && ci == 0) begin
            ci  = 2;
            dur = 5;
            lt  = R;
         end
         setin(lt, ($urandom_range(0, 99) < 15));
         if (m_fault) stuck++;
         if ($urandom_range(0, 299) == 0 || stuck > 15) begin
            do_reset();
            stuck = 0;
         end else begin
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ped_signal_ctrl.md
PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 SHALL have parameter WALK_TIME, default 8: number of cycles the steady WALK indication is held.
REQ-002 SHALL have parameter FLASH_TIME, default 12: number of cycles of flashing DONT_WALK clearance; legal range 1..63.
REQ-003 SHALL have parameter FLASH_HALF, default 2: number of cycles per on or off half-period of the flash.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port light, input, 3 bits: vehicle lamp state, one-hot {RED,YELLOW,GREEN}; 3'b100 means RED.
REQ-007 SHALL have port ped_btn, input, 1 bit: pedestrian request, synchronous, sampled every cycle.
REQ-008 SHALL have port walk, output, 1 bit: steady WALK lamp.
REQ-009 SHALL have port dont_walk, output, 1 bit: DONT_WALK lamp, either steady or flashing.
REQ-010 SHALL have port countdown, output, 6 bits: clearance cycles remaining during flash; 0 at all other times.
REQ-011 SHALL have port req_pending, output, 1 bit: a pedestrian request is latched and not yet served.
REQ-012 SHALL have port fault, output, 1 bit: sticky flag for an illegal vehicle lamp state.

Function
REQ-013 SHALL implement exactly four states: IDLE (steady DONT_WALK), WALK, FLASH and FAULT.
REQ-014 SHALL register light into light_d every cycle and SHALL define red_rise as light==3'b100 while light_d!=3'b100.
REQ-015 SHALL move from IDLE to WALK on red_rise when req_pending==1 or ped_btn==1.
- On the same edge: walk=1, dont_walk=0, req_pending=0.
REQ-016 SHALL hold walk high for exactly WALK_TIME cycles, then enter FLASH.
REQ-017 SHALL keep FLASH for exactly FLASH_TIME cycles.
- countdown shows FLASH_TIME-1 on the first FLASH cycle and decrements by 1 each cycle down to 0.
- walk=0 throughout FLASH.
REQ-018 SHALL drive dont_walk in FLASH as 1 for FLASH_HALF cycles, then 0 for FLASH_HALF cycles, repeating; the first FLASH cycle is always 1.
REQ-019 SHALL return to IDLE after the last FLASH cycle: dont_walk=1, countdown=0.
REQ-020 SHALL abort to IDLE on the next edge if light!=3'b100 is sampled in WALK or FLASH: walk=0, dont_walk=1, countdown=0.
REQ-021 SHALL set req_pending on ped_btn sampled in IDLE or FLASH.
- ped_btn sampled in WALK is ignored.
- If ped_btn coincides with WALK entry, entry wins and req_pending=0.
REQ-022 SHALL leave req_pending set if red_rise does not occur; there is no timeout.
REQ-023 SHALL enter FAULT on the next edge, with priority over all other transitions, when either condition is sampled:
- light is not one of 3'b001, 3'b010, 3'b100;
- light_d==3'b001 and light==3'b100 (GREEN-to-RED without YELLOW).
REQ-024 SHALL hold FAULT until reset: fault=1, walk=0, dont_walk=1, countdown=0, req_pending=0, ped_btn ignored.
REQ-025 SHALL drive walk, dont_walk, countdown, req_pending and fault directly from registers, with no combinational path from inputs to outputs.
REQ-026 SHALL never assert walk and dont_walk in the same cycle.

Reset
REQ-027 SHALL, while reset==0, asynchronously force the following values:
- state=IDLE, light_d=3'b000, all timers 0;
- walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0.
REQ-028 SHALL, if reset is asserted mid-WALK or mid-FLASH, immediately show steady DONT_WALK and discard any pending request.
REQ-029 SHALL not evaluate the GREEN-to-RED check on the first edge after reset release, because light_d is 3'b000.

Verification
REQ-030 SHALL verify the normal cycle with defaults: ped_btn pulse in GREEN, then YELLOW, then RED held 31 cycles.
- Expect walk=1 for 8 cycles starting at the red_rise edge.
- Then FLASH for 12 cycles: countdown 11..0, dont_walk pattern 1,1,0,0 repeating.
- Then steady dont_walk=1 and req_pending=0.
REQ-031 SHALL verify no request: RED phase with ped_btn=0 throughout -> walk stays 0 and dont_walk stays 1.
REQ-032 SHALL verify abort: light changes to GREEN at WALK cycle 3 -> next cycle walk=0, dont_walk=1, countdown=0.
- Note: light leaving RED for GREEN is itself a legal transition, so no fault is expected here.
REQ-033 SHALL verify requests around FLASH:
- ped_btn during WALK -> req_pending remains 0.
- ped_btn during FLASH -> req_pending=1, and WALK is entered at the next red_rise.
REQ-034 SHALL verify fault detection:
- light=3'b011 -> fault=1 next cycle, sticky through later legal lamp states.
- light 3'b001 to 3'b100 -> fault=1.
- Both cases clear only on reset.
REQ-035 SHALL verify reset mid-FLASH with countdown=5: drive reset=0 -> immediately countdown=0, dont_walk=1, walk=0, req_pending=0.
